// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_unit
// Purpose  : Execute-stage branch resolver for the 5-stage MIPS pipeline.
//            Resolves beq/bne/j from the ID/EX slot, computes the target,
//            and drives a one-cycle branch pulse plus baddr towards the PC.
//            On a taken branch it raises flush for FLUSH_CYCLES unstalled
//            cycles and squashes any branch request seen during that window.
// Ports    : clk, reset (sync, active-high)
//            valid_in, stall, is_beq, is_bne, is_j   - request qualifiers
//            rs_data, rt_data [31:0]                  - compare operands
//            pc_plus4 [31:0], instr_idx [25:0]        - target inputs
//            branch, baddr [31:0]                     - to PC
//            flush                                    - squash IF/ID, ID/EX
//            stat_resolved, stat_taken [31:0]         - only with
//                                                       BRANCH_STATS_EN
// Config   : `define BRANCH_STATS_EN to add the resolved/taken counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_unit #(
  parameter int FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        stall,
  input  logic        is_beq,
  input  logic        is_bne,
  input  logic        is_j,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_idx,
`ifdef BRANCH_STATS_EN
  output logic [31:0] stat_resolved,
  output logic [31:0] stat_taken,
`endif
  output logic        branch,
  output logic [31:0] baddr,
  output logic        flush
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        branch_q;
  logic [31:0] baddr_q;
  logic        flush_q;

  logic        is_branch;
  logic        accept;
  logic        operands_eq;
  logic        taken;
  logic [31:0] rel_target;
  logic [31:0] abs_target;
  logic [31:0] target;

  assign is_branch   = is_j | is_beq | is_bne;
  assign accept      = valid_in & ~stall & (state_q == IDLE) & is_branch;
  assign operands_eq = (rs_data == rt_data);

  // j wins over beq, beq over bne; if neither j nor beq is set, it is a bne.
  assign taken = is_j | (is_beq ? operands_eq : ~operands_eq);

  // Sign-extended word offset; the add wraps modulo 2^32.
  assign rel_target = pc_plus4 + {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};
  assign abs_target = {pc_plus4[31:28], instr_idx, 2'b00};
  assign target     = is_j ? abs_target : rel_target;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      branch_q <= 1'b0;
      baddr_q  <= 32'd0;
      flush_q  <= 1'b0;
    end else begin
      // The pulse lasts exactly one cycle regardless of stall.
      branch_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && taken) begin
            branch_q <= 1'b1;
            baddr_q  <= target;
            flush_q  <= 1'b1;
            cnt_q    <= FLUSH_LOAD;
            state_q  <= FLUSH;
          end
        end
        FLUSH: begin
          // Counter only advances on unstalled cycles so flush covers
          // FLUSH_CYCLES real pipeline advances.
          if (!stall) begin
            if (cnt_q == 4'd1) begin
              cnt_q   <= 4'd0;
              flush_q <= 1'b0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign branch = branch_q;
  assign baddr  = baddr_q;
  assign flush  = flush_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] resolved_q;
  logic [31:0] taken_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      resolved_q <= 32'd0;
      taken_q    <= 32'd0;
    end else if (accept) begin
      resolved_q <= resolved_q + 32'd1;
      if (taken) begin
        taken_q <= taken_q + 32'd1;
      end
    end
  end

  assign stat_resolved = resolved_q;
  assign stat_taken    = taken_q;
`endif

endmodule
`default_nettype wire
